// File: rtl/hazard_sched.sv
// hazard_sched: E/M/W write scoreboard driving the F/D stall, the E bubble and the D/E forward selects.
module hazard_sched #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             freeze_i,
   input  logic             d_valid_i,
   input  logic [4:0]       d_rs_i,
   input  logic [4:0]       d_rt_i,
   input  logic [1:0]       d_tuse_rs_i,
   input  logic [1:0]       d_tuse_rt_i,
   input  logic             d_we_i,
   input  logic [4:0]       d_dst_i,
   input  logic [1:0]       d_T_i,
   output logic             stall_o,
   output logic [1:0]       fwd_d_rs_o,
   output logic [1:0]       fwd_d_rt_o,
   output logic [1:0]       fwd_e_rs_o,
   output logic [1:0]       fwd_e_rt_o,
   output logic [CNT_W-1:0] stall_cnt_o
);
   logic             e_v_q, m_v_q, w_v_q, e_v_d, m_v_d, w_v_d;
   logic [4:0]       e_dst_q, m_dst_q, w_dst_q, e_dst_d, m_dst_d, w_dst_d;
   logic [4:0]       e_rs_q, e_rt_q, e_rs_d, e_rt_d;
   logic [1:0]       e_tnew_q, m_tnew_q, e_tnew_d, m_tnew_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       dr [2];
   logic [4:0]       er [2];
   logic [1:0]       tu [2];
   logic [1:0]       me, mm, mw, hz, em, ew;
   logic [1:0]       ytnew [2];
   logic [1:0]       fd [2];
   logic [1:0]       fe [2];

   assign dr[0] = d_rs_i;
   assign dr[1] = d_rt_i;
   assign er[0] = e_rs_q;
   assign er[1] = e_rt_q;
   assign tu[0] = d_tuse_rs_i;
   assign tu[1] = d_tuse_rt_i;

   // W always carries tnew 0, so it can forward but never cause a stall
   always_comb begin
      me = '0;
      mm = '0;
      mw = '0;
      hz = '0;
      em = '0;
      ew = '0;
      for (int i = 0; i < 2; i++) begin
         me[i] = e_v_q && e_dst_q == dr[i] && dr[i] != 5'd0;
         mm[i] = m_v_q && m_dst_q == dr[i] && dr[i] != 5'd0;
         mw[i] = w_v_q && w_dst_q == dr[i] && dr[i] != 5'd0;
         ytnew[i] = me[i] ? e_tnew_q : mm[i] ? m_tnew_q : 2'd0;
         hz[i] = tu[i] != 2'd3 && (me[i] || mm[i]) && tu[i] < ytnew[i];
         fd[i] = me[i] ? (e_tnew_q == 2'd0 ? 2'd1 : 2'd0) :
                 mm[i] ? (m_tnew_q == 2'd0 ? 2'd2 : 2'd0) :
                 mw[i] ? 2'd3 : 2'd0;
         em[i] = m_v_q && m_dst_q == er[i] && er[i] != 5'd0;
         ew[i] = w_v_q && w_dst_q == er[i] && er[i] != 5'd0;
         fe[i] = (em[i] && m_tnew_q == 2'd0) ? 2'd2 : ew[i] ? 2'd3 : 2'd0;
      end
   end

   assign stall_o     = d_valid_i && |hz;
   assign fwd_d_rs_o  = fd[0];
   assign fwd_d_rt_o  = fd[1];
   assign fwd_e_rs_o  = fe[0];
   assign fwd_e_rt_o  = fe[1];
   assign stall_cnt_o = cnt_q;

   always_comb begin
      e_v_d    = stall_o ? 1'b0 : d_valid_i && d_we_i && d_dst_i != 5'd0;
      e_dst_d  = stall_o ? 5'd0 : d_dst_i;
      e_tnew_d = stall_o ? 2'd0 : d_T_i;
      e_rs_d   = stall_o ? 5'd0 : d_rs_i;
      e_rt_d   = stall_o ? 5'd0 : d_rt_i;
      m_v_d    = e_v_q;
      m_dst_d  = e_dst_q;
      m_tnew_d = e_tnew_q == 2'd0 ? 2'd0 : e_tnew_q - 2'd1;
      w_v_d    = m_v_q;
      w_dst_d  = m_dst_q;
      cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, stall_o && !(&cnt_q)};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         e_v_q    <= 1'b0;
         e_dst_q  <= '0;
         e_tnew_q <= '0;
         e_rs_q   <= '0;
         e_rt_q   <= '0;
         m_v_q    <= 1'b0;
         m_dst_q  <= '0;
         m_tnew_q <= '0;
         w_v_q    <= 1'b0;
         w_dst_q  <= '0;
         cnt_q    <= '0;
      end else if (!freeze_i) begin
         e_v_q    <= e_v_d;
         e_dst_q  <= e_dst_d;
         e_tnew_q <= e_tnew_d;
         e_rs_q   <= e_rs_d;
         e_rt_q   <= e_rt_d;
         m_v_q    <= m_v_d;
         m_dst_q  <= m_dst_d;
         m_tnew_q <= m_tnew_d;
         w_v_q    <= w_v_d;
         w_dst_q  <= w_dst_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

// File: tb/tb_hazard_sched.sv
// tb_hazard_sched: directed scenarios for hazard_sched with a 2-bit counter copy for saturation.
module tb_hazard_sched;
   logic clk = 1'b0, rst_n = 1'b0, freeze = 1'b0;
   logic d_valid, d_we;
   logic [4:0] d_rs, d_rt, d_dst;
   logic [1:0] tu_rs, tu_rt, d_T;
   logic stall, stall2;
   logic [1:0] fdrs, fdrt, fers, fert, x0, x1, x2, x3;
   logic [15:0] cnt;
   logic [1:0] cnt2;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   hazard_sched dut (.clk_i(clk), .rst_ni(rst_n), .freeze_i(freeze), .d_valid_i(d_valid),
      .d_rs_i(d_rs), .d_rt_i(d_rt), .d_tuse_rs_i(tu_rs), .d_tuse_rt_i(tu_rt), .d_we_i(d_we),
      .d_dst_i(d_dst), .d_T_i(d_T), .stall_o(stall), .fwd_d_rs_o(fdrs), .fwd_d_rt_o(fdrt),
      .fwd_e_rs_o(fers), .fwd_e_rt_o(fert), .stall_cnt_o(cnt));

   hazard_sched #(.CNT_W(2)) dut2 (.clk_i(clk), .rst_ni(rst_n), .freeze_i(freeze), .d_valid_i(d_valid),
      .d_rs_i(d_rs), .d_rt_i(d_rt), .d_tuse_rs_i(tu_rs), .d_tuse_rt_i(tu_rt), .d_we_i(d_we),
      .d_dst_i(d_dst), .d_T_i(d_T), .stall_o(stall2), .fwd_d_rs_o(x0), .fwd_d_rt_o(x1),
      .fwd_e_rs_o(x2), .fwd_e_rt_o(x3), .stall_cnt_o(cnt2));

   task automatic set_d(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] urs, input logic [1:0] urt, input logic we,
                        input logic [4:0] dst, input logic [1:0] t);
      d_valid = v; d_rs = rs; d_rt = rt; tu_rs = urs; tu_rt = urt; d_we = we; d_dst = dst; d_T = t;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      freeze = 1'b0;
      rst_n = 1'b0;
      set_d(0, 0, 0, 3, 3, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      freeze = 1'b0;
      rst_n = 1'b0;
      set_d(1, 5, 6, 0, 0, 1, 5, 2);
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall act=%0d exp=0", stall); end
      checks++; if ({fdrs, fdrt, fers, fert} !== 8'h00) begin failures++; $display("FAIL reset_fwd act=%h exp=00", {fdrs, fdrt, fers, fert}); end
      checks++; if (cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt act=%0d exp=0", cnt); end
      do_reset();
   endtask

   task automatic test_alu_fwd;
      do_reset();
      set_d(1, 0, 0, 3, 3, 1, 3, 1);
      tick();
      set_d(1, 3, 0, 1, 3, 0, 0, 0);
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall act=%0d exp=0", stall); end
      checks++; if (fdrs !== 2'd0) begin failures++; $display("FAIL alu_fwd_d_rs act=%0d exp=0", fdrs); end
      tick();
      set_d(0, 0, 0, 3, 3, 0, 0, 0);
      checks++; if (fers !== 2'd2) begin failures++; $display("FAIL alu_fwd_e_rs act=%0d exp=2", fers); end
   endtask

   task automatic test_load_use;
      do_reset();
      set_d(1, 0, 0, 3, 3, 1, 5, 2);
      tick();
      set_d(1, 5, 0, 0, 3, 0, 0, 0);
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall0 act=%0d exp=1", stall); end
      tick();
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall1 act=%0d exp=1", stall); end
      checks++; if (cnt !== 16'd1) begin failures++; $display("FAIL lu_cnt1 act=%0d exp=1", cnt); end
      tick();
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_release act=%0d exp=0", stall); end
      checks++; if (fdrs !== 2'd3) begin failures++; $display("FAIL lu_fwd_d_rs act=%0d exp=3", fdrs); end
      checks++; if (cnt !== 16'd2) begin failures++; $display("FAIL lu_cnt2 act=%0d exp=2", cnt); end
      checks++; if (cnt2 !== 2'd2) begin failures++; $display("FAIL lu_cnt2_small act=%0d exp=2", cnt2); end
   endtask

   task automatic test_back_to_back;
      set_d(1, 0, 0, 3, 3, 1, 6, 2);
      tick();
      set_d(1, 6, 0, 0, 3, 0, 0, 0);
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL b2b_stall act=%0d exp=1", stall); end
      tick();
      tick();
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL b2b_release act=%0d exp=0", stall); end
      checks++; if (cnt !== 16'd4) begin failures++; $display("FAIL b2b_cnt act=%0d exp=4", cnt); end
      checks++; if (cnt2 !== 2'd3) begin failures++; $display("FAIL b2b_cnt_sat act=%0d exp=3", cnt2); end
   endtask

   task automatic test_store_data;
      do_reset();
      set_d(1, 0, 0, 3, 3, 1, 5, 2);
      tick();
      set_d(1, 5, 5, 3, 2, 0, 0, 0);
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL st_stall act=%0d exp=0", stall); end
      tick();
      checks++; if (fert !== 2'd0) begin failures++; $display("FAIL st_fwd_e_rt_m act=%0d exp=0", fert); end
      tick();
      set_d(0, 0, 0, 3, 3, 0, 0, 0);
      checks++; if (fert !== 2'd3) begin failures++; $display("FAIL st_fwd_e_rt_w act=%0d exp=3", fert); end
   endtask

   task automatic test_zero_reg;
      do_reset();
      set_d(1, 0, 0, 3, 3, 1, 0, 1);
      tick();
      set_d(1, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL r0_stall act=%0d exp=0", stall); end
      checks++; if (fdrs !== 2'd0) begin failures++; $display("FAIL r0_fwd_d_rs act=%0d exp=0", fdrs); end
   endtask

   task automatic test_youngest;
      do_reset();
      set_d(1, 0, 0, 3, 3, 1, 7, 0);
      tick();
      tick();
      set_d(1, 7, 7, 0, 0, 0, 0, 0);
      checks++; if (fdrs !== 2'd1) begin failures++; $display("FAIL yg_fwd_d_rs act=%0d exp=1", fdrs); end
      checks++; if (fdrt !== 2'd1) begin failures++; $display("FAIL yg_fwd_d_rt act=%0d exp=1", fdrt); end
      set_d(0, 0, 0, 3, 3, 0, 0, 0);
      tick();
      set_d(1, 7, 0, 0, 3, 0, 0, 0);
      checks++; if (fdrs !== 2'd2) begin failures++; $display("FAIL yg_fwd_d_rs_m act=%0d exp=2", fdrs); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL yg_stall act=%0d exp=0", stall); end
   endtask

   task automatic test_freeze_reset;
      do_reset();
      set_d(1, 0, 0, 3, 3, 1, 5, 2);
      tick();
      set_d(1, 5, 0, 0, 3, 0, 0, 0);
      freeze = 1'b1;
      repeat (3) tick();
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL fz_stall act=%0d exp=1", stall); end
      checks++; if (cnt !== 16'd0) begin failures++; $display("FAIL fz_cnt act=%0d exp=0", cnt); end
      freeze = 1'b0;
      tick();
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL fz_after_stall act=%0d exp=1", stall); end
      checks++; if (cnt !== 16'd1) begin failures++; $display("FAIL fz_after_cnt act=%0d exp=1", cnt); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_mid_stall act=%0d exp=0", stall); end
      checks++; if (cnt !== 16'd0) begin failures++; $display("FAIL rst_mid_cnt act=%0d exp=0", cnt); end
      do_reset();
   endtask

   initial begin
      test_reset();
      test_alu_fwd();
      test_load_use();
      test_back_to_back();
      test_store_data();
      test_zero_reg();
      test_youngest();
      test_freeze_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
